// File: rtl/bt_uart_rx.sv
// -----------------------------------------------------------------------------
// bt_uart_rx
//   8N1 UART receiver for the serial Bluetooth module. The asynchronous RXD
//   line is double-flopped. A falling edge in IDLE starts a frame. The start
//   bit is re-checked at mid-bit to reject glitches. Each data bit and the
//   stop bit are then sampled once per bit time, at their midpoints. A good
//   frame updates uart_data with a one-cycle uart_done. A low stop bit gives a
//   one-cycle frame_err instead and leaves uart_data untouched.
//
// Parameters
//   CLK_FREQ   system clock in Hz
//   UART_BPS   baud rate; CLK_FREQ/UART_BPS must be >= 16
//
// Ports
//   sys_clk    system clock, rising edge
//   sys_rst    asynchronous active-high reset
//   uart_rxd   raw serial input, idles high, asynchronous to sys_clk
//   uart_data  last correctly framed byte (LSB = first data bit)
//   uart_done  one-cycle strobe when uart_data has just been updated
//   frame_err  one-cycle strobe when the stop bit was sampled low
//   rx_busy    high while a frame is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module bt_uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT);

    // Sample points: mid start bit after half a bit, then one full bit apart,
    // which keeps every later sample near its bit's midpoint.
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(BPS_CNT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BPS_CNT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    generate
        if (BPS_CNT < 16) begin : g_bps_chk
            $error("bt_uart_rx: CLK_FREQ/UART_BPS must be >= 16");
        end
    endgenerate

    logic [1:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             rxd_m;
    logic             rxd_s;
    logic             rxd_d;
    logic             start_edge;

    // Synchronizer plus one history flop for edge detection. Reset to the
    // idle-high level so that reset release cannot look like a start edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= uart_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    // A line held low, for example a break after a frame error, does not
    // restart reception. It must first go high and then fall again.
    assign start_edge = rxd_d & ~rxd_s;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            uart_data <= '0;
            uart_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (start_edge) state <= START;
                end
                START: begin
                    if (clk_cnt == CNT_HALF_END) begin
                        clk_cnt <= '0;
                        // Line high again at mid start bit: it was a glitch.
                        if (rxd_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_BIT_END) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rxd_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == CNT_BIT_END) begin
                        clk_cnt <= '0;
                        // Leaving at mid stop bit gives half a bit of idle
                        // time. This catches a back-to-back start edge.
                        state   <= IDLE;
                        if (rxd_s) begin
                            uart_data <= shift_reg;
                            uart_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_bt_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_bt_uart_rx
//   Self-checking bench for bt_uart_rx with BPS_CNT = 16. A table of single
//   frames is followed by hand-written sequences: latency, back-to-back
//   frames, a start glitch, a frame error followed by a break, a mid-frame
//   reset, and a sweep of all 256 byte values.
// -----------------------------------------------------------------------------
module tb_bt_uart_rx;

    localparam int CLK_FREQ = 1_600_000;
    localparam int UART_BPS = 100_000;
    localparam int BPS      = CLK_FREQ / UART_BPS;

    logic       sys_clk  = 1'b0;
    logic       sys_rst  = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    logic       rx_busy;

    bt_uart_rx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .uart_rxd (uart_rxd),
        .uart_data(uart_data),
        .uart_done(uart_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Monitor: samples outputs on the falling edge, away from the active edge.
    int         cyc = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         wide_cnt = 0;
    int         last_done_cyc = 0;
    int         busy_cycles = 0;
    int         busy_low_cnt = 0;
    logic       watch_busy = 1'b0;
    logic       done_prev = 1'b0;
    logic [7:0] rx_q[$];

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (uart_done) begin
                done_cnt++;
                rx_q.push_back(uart_data);
                last_done_cyc = cyc;
                if (done_prev) wide_cnt++;
            end
            if (frame_err) ferr_cnt++;
            if (uart_done && frame_err) both_cnt++;
            if (rx_busy) busy_cycles++;
            if (watch_busy && !rx_busy) busy_low_cnt++;
        end
        done_prev = uart_done;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rxd = v;
        repeat (BPS) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_done;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0, f0, lat, start_cyc;

        vecs[0] = '{8'h13, 1'b1, 8'h13, 1, 0};
        vecs[1] = '{8'h5A, 1'b1, 8'h5A, 1, 0};
        vecs[2] = '{8'hC3, 1'b0, 8'h5A, 0, 1};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[5] = '{8'h7E, 1'b0, 8'hFF, 0, 1};

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_uart_data", {24'h0, uart_data}, 32'h0);
        chk("rst_uart_done", {31'h0, uart_done}, 32'h0);
        chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
        chk("rst_rx_busy",   {31'h0, rx_busy},   32'h0);
        sys_rst = 1'b0;
        repeat (BPS) @(negedge sys_clk);

        // Table-driven single frames, each followed by one idle bit
        foreach (vecs[i]) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop);
            send_bit(1'b1);
            chk($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
            chk($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            chk($sformatf("vec%0d_data", i), {24'h0, uart_data}, {24'h0, vecs[i].exp_data});
            chk($sformatf("vec%0d_idle", i), {31'h0, rx_busy}, 32'h0);
        end

        // 1: 8'h13, latency and busy throughout the frame
        d0 = done_cnt;
        f0 = ferr_cnt;
        busy_low_cnt = 0;
        start_cyc = cyc;
        fork
            send_frame(8'h13, 1'b1);
            begin
                repeat (4) @(negedge sys_clk);
                watch_busy = 1'b1;
                repeat (146) @(negedge sys_clk);
                watch_busy = 1'b0;
            end
        join
        send_bit(1'b1);
        lat = last_done_cyc - start_cyc;
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_data", {24'h0, uart_data}, 32'h13);
        chk("t1_ferr", ferr_cnt - f0, 0);
        chk("t1_latency_window", (lat >= 154 && lat <= 158) ? 1 : 0, 1);
        chk("t1_busy_low_in_frame", busy_low_cnt, 0);

        // 2: back-to-back frames with no idle gap
        rx_q.delete();
        send_frame(8'h30, 1'b1);
        send_frame(8'h31, 1'b1);
        send_bit(1'b1);
        chk("t2_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            chk("t2_first",  {24'h0, rx_q[0]}, 32'h30);
            chk("t2_second", {24'h0, rx_q[1]}, 32'h31);
        end

        // 3: 4-cycle low glitch while idle
        d0 = done_cnt;
        f0 = ferr_cnt;
        busy_cycles = 0;
        uart_rxd = 1'b0;
        repeat (4) @(negedge sys_clk);
        uart_rxd = 1'b1;
        repeat (3 * BPS) @(negedge sys_clk);
        chk("t3_done", done_cnt - d0, 0);
        chk("t3_ferr", ferr_cnt - f0, 0);
        chk("t3_busy_seen", (busy_cycles > 0) ? 1 : 0, 1);
        chk("t3_busy_max9", (busy_cycles <= 9) ? 1 : 0, 1);
        chk("t3_idle", {31'h0, rx_busy}, 32'h0);

        // 4: framing error, then a break, then recovery
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        repeat (3 * BPS) @(negedge sys_clk);
        chk("t4_ferr", ferr_cnt - f0, 1);
        chk("t4_no_done", done_cnt - d0, 0);
        chk("t4_data_held", {24'h0, uart_data}, 32'h31);
        chk("t4_break_idle", {31'h0, rx_busy}, 32'h0);
        send_bit(1'b1);
        d0 = done_cnt;
        send_frame(8'h02, 1'b1);
        send_bit(1'b1);
        chk("t4_recover_done", done_cnt - d0, 1);
        chk("t4_recover_data", {24'h0, uart_data}, 32'h02);

        // 5: asynchronous reset during data bit 4 of 8'hFF
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * BPS + 6) @(negedge sys_clk);
                #3 sys_rst = 1'b1;
                #1;
                chk("t5_rst_data", {24'h0, uart_data}, 32'h0);
                chk("t5_rst_done", {31'h0, uart_done}, 32'h0);
                chk("t5_rst_ferr", {31'h0, frame_err}, 32'h0);
                chk("t5_rst_busy", {31'h0, rx_busy}, 32'h0);
                repeat (20) @(negedge sys_clk);
                sys_rst = 1'b0;
            end
        join
        send_bit(1'b1);
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h11, 1'b1);
        send_bit(1'b1);
        chk("t5_after_done", done_cnt - d0, 1);
        chk("t5_after_ferr", ferr_cnt - f0, 0);
        chk("t5_after_data", {24'h0, uart_data}, 32'h11);

        // 6: all byte values with random idle gaps
        rx_q.delete();
        d0 = done_cnt;
        f0 = ferr_cnt;
        for (int b = 0; b < 256; b++) begin
            send_frame(8'(b), 1'b1);
            uart_rxd = 1'b1;
            repeat ($urandom_range(0, 20)) @(negedge sys_clk);
        end
        repeat (BPS) @(negedge sys_clk);
        chk("t6_done_cnt", done_cnt - d0, 256);
        chk("t6_ferr_cnt", ferr_cnt - f0, 0);
        for (int b = 0; b < 256 && b < rx_q.size(); b++)
            chk($sformatf("t6_byte_%0d", b), {24'h0, rx_q[b]}, b);

        chk("done_ferr_overlap", both_cnt, 0);
        chk("done_pulse_width", wide_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
